// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the hazard controller
// Purpose: multi-cycle sequencer state encoding, architectural x0 index and
//          default parameter values used by hazard_controller and sat_counter.
package hazard_controller_pkg;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int DEFAULT_CNT_W      = 32;
    localparam int DEFAULT_MD_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Purpose: counts cycles where inc is high, sticking at all-ones.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   inc          count this cycle
//   clr          zero the counter at the edge (wins over inc)
//   count        current count value
module sat_counter
    import hazard_controller_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch hazard and mul-div stall sequencer
// Purpose: drives stall and flush enables for the IF/ID, ID/EX and EX/MEM
//          registers and sequences multi-cycle EX ops via md_start/md_done.
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   rs1D, rs2D                  source registers of the ID instruction
//   rdE, MemReadE               destination / load flag of the EX instruction
//   PCSrcE                      taken branch or jump resolved in EX
//   MulDivE, md_done            multi-cycle op in EX and its completion pulse
//   perf_clr                    clears both performance counters
//   StallF/D/E, FlushD/E/M      pipeline register controls
//   md_start, md_busy, md_error multi-cycle handshake and status
//   stall_cycles, flush_events  saturating performance counters
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MD_TIMEOUT = DEFAULT_MD_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             md_done,
    input  logic             perf_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int             TO_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    md_state_t       state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
    logic            lu;
    logic            branch_flush;

    assign lu = MemReadE && (rdE != REG_X0) && ((rdE == rs1D) || (rdE == rs2D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            MD_IDLE: begin
                // A taken branch squashes the EX op path, so only start when not redirecting.
                if (MulDivE && !PCSrcE) begin
                    state_d = MD_BUSY;
                    to_d    = '0;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    state_d = MD_IDLE;
                end else if (to_q == TO_LAST) begin
                    state_d = MD_IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held so the Mealy
    // start pulse cannot leak out from live inputs during reset.
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        branch_flush = 1'b0;
        if (!reset) begin
            case (state_q)
                MD_IDLE: begin
                    if (PCSrcE) begin
                        FlushD       = 1'b1;
                        FlushE       = 1'b1;
                        branch_flush = 1'b1;
                    end else if (MulDivE) begin
                        md_start = 1'b1;
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                    end else if (lu) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    // FlushD/FlushE stay low here so the held EX op survives a load-use match.
                    if (!md_done) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_error = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .clr   (perf_clr),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_flush),
        .clr   (perf_clr),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int CNT_W      = 6;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs1D, rs2D, rdE;
    logic             MemReadE, PCSrcE, MulDivE, md_done, perf_clr;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic             md_start, md_busy, md_error;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int vectors     = 0;
    int miscompares = 0;

    hazard_controller #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .rdE          (rdE),
        .MemReadE     (MemReadE),
        .PCSrcE       (PCSrcE),
        .MulDivE      (MulDivE),
        .md_done      (md_done),
        .perf_clr     (perf_clr),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_error     (md_error),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: "in a multi-cycle op" flag, BUSY cycles spent so far, sticky error, counts.
    bit m_busy = 0, n_busy = 0;
    int m_spent = 0, n_spent = 0;
    bit m_err = 0, n_err = 0;
    int m_stall = 0, n_stall = 0;
    int m_flush = 0, n_flush = 0;

    always @(negedge clk) begin
        bit e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_start, e_busy, lu, br;
        e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0;
        e_start = 0; e_busy = 0; br = 0;
        lu = MemReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        if (!reset) begin
            if (!m_busy) begin
                if (PCSrcE) begin
                    e_fd = 1; e_fe = 1; br = 1;
                end else if (MulDivE) begin
                    e_start = 1; e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
                end else if (lu) begin
                    e_sf = 1; e_sd = 1; e_fe = 1;
                end
            end else begin
                e_busy = 1;
                if (!md_done) begin
                    e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
                end
            end
        end
        chk("StallF", StallF, e_sf);
        chk("StallD", StallD, e_sd);
        chk("StallE", StallE, e_se);
        chk("FlushD", FlushD, e_fd);
        chk("FlushE", FlushE, e_fe);
        chk("FlushM", FlushM, e_fm);
        chk("md_start", md_start, e_start);
        chk("md_busy", md_busy, e_busy);
        chk("md_error", md_error, reset ? 0 : m_err);
        chk("stall_cycles", stall_cycles, reset ? 0 : m_stall);
        chk("flush_events", flush_events, reset ? 0 : m_flush);
        if (reset) begin
            n_busy = 0; n_spent = 0; n_err = 0; n_stall = 0; n_flush = 0;
        end else begin
            n_stall = perf_clr ? 0 : (e_sf ? ((m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX) : m_stall);
            n_flush = perf_clr ? 0 : (br ? ((m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX) : m_flush);
            n_busy = m_busy; n_spent = m_spent; n_err = m_err;
            if (!m_busy && e_start) begin
                n_busy = 1; n_spent = 0;
            end else if (m_busy) begin
                if (md_done) begin
                    n_busy = 0;
                end else begin
                    n_spent = m_spent + 1;
                    if (n_spent == MD_TIMEOUT) begin
                        n_busy = 0; n_err = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        m_busy = n_busy; m_spent = n_spent; m_err = n_err;
        m_stall = n_stall; m_flush = n_flush;
    end

    task automatic clr_inputs();
        rs1D = 0; rs2D = 0; rdE = 0;
        MemReadE = 0; PCSrcE = 0; MulDivE = 0; md_done = 0; perf_clr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_StallF", StallF, 0);
        chk("rst_md_error", md_error, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        next_cycle();
        reset = 0;

        // Load-use on rs1, then the same pattern through x0.
        MemReadE = 1; rdE = 5; rs1D = 5; rs2D = 9;
        @(negedge clk);
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_StallE", StallE, 0);
        next_cycle();
        clr_inputs();
        @(negedge clk);
        chk("lu_count", stall_cycles, 1);
        chk("lu_release", StallF, 0);
        next_cycle();
        MemReadE = 1; rdE = 0; rs1D = 0; rs2D = 0;
        @(negedge clk);
        chk("x0_StallF", StallF, 0);
        chk("x0_FlushE", FlushE, 0);
        next_cycle();
        clr_inputs();
        perf_clr = 1;
        next_cycle();
        perf_clr = 0;

        // Multi-cycle op: start at cycle 0, done at cycle 4, load-use noise while busy.
        MulDivE = 1;
        @(negedge clk);
        chk("md_c0_start", md_start, 1);
        chk("md_c0_StallE", StallE, 1);
        chk("md_c0_FlushM", FlushM, 1);
        chk("md_c0_busy", md_busy, 0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            MemReadE = 1; rdE = 7; rs1D = 7;
            @(negedge clk);
            chk("md_busy_start", md_start, 0);
            chk("md_busy_flag", md_busy, 1);
            chk("md_busy_StallF", StallF, 1);
            chk("md_busy_FlushE", FlushE, 0);
        end
        next_cycle();
        MemReadE = 0; md_done = 1;
        @(negedge clk);
        chk("md_done_StallF", StallF, 0);
        chk("md_done_FlushM", FlushM, 0);
        chk("md_done_busy", md_busy, 1);
        next_cycle();
        clr_inputs();
        @(negedge clk);
        chk("md_c5_busy", md_busy, 0);
        chk("md_c5_stalls", stall_cycles, 4);

        // Branch and load-use together.
        next_cycle();
        PCSrcE = 1; MemReadE = 1; rdE = 3; rs2D = 3;
        @(negedge clk);
        chk("br_FlushD", FlushD, 1);
        chk("br_FlushE", FlushE, 1);
        chk("br_StallF", StallF, 0);
        next_cycle();
        clr_inputs();
        @(negedge clk);
        chk("br_count", flush_events, 1);

        // Timeout: no md_done for MD_TIMEOUT BUSY cycles.
        next_cycle();
        MulDivE = 1;
        next_cycle();
        MulDivE = 0;
        repeat (7) next_cycle();
        @(negedge clk);
        chk("to_last_err", md_error, 0);
        chk("to_last_busy", md_busy, 1);
        chk("to_last_StallF", StallF, 1);
        next_cycle();
        @(negedge clk);
        chk("to_err", md_error, 1);
        chk("to_idle", md_busy, 0);
        chk("to_StallF", StallF, 0);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("to_sticky", md_error, 1);

        // Reset at BUSY cycle 2.
        next_cycle();
        MulDivE = 1;
        next_cycle();
        next_cycle();
        reset = 1;
        #1;
        chk("rstb_busy", md_busy, 0);
        chk("rstb_StallF", StallF, 0);
        chk("rstb_FlushM", FlushM, 0);
        chk("rstb_start", md_start, 0);
        chk("rstb_err", md_error, 0);
        chk("rstb_cnt", stall_cycles, 0);
        next_cycle();
        reset = 0;
        MulDivE = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_start", md_start, 0);
            chk("post_rst_err", md_error, 0);
            chk("post_rst_flush", flush_events, 0);
            next_cycle();
        end

        // Randomized phase checked by the model on every negedge.
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            rs1D     = 5'($urandom_range(0, 3));
            rs2D     = 5'($urandom_range(0, 3));
            rdE      = 5'($urandom_range(0, 3));
            MemReadE = ($urandom_range(0, 9) < 3);
            perf_clr = ($urandom_range(0, 199) == 0);
            if (m_busy) begin
                md_done = ($urandom_range(0, 99) < 15);
                PCSrcE  = 0;
            end else begin
                md_done = ($urandom_range(0, 19) == 0);
                MulDivE = ($urandom_range(0, 9) == 0);
                PCSrcE  = MulDivE ? 1'b0 : ($urandom_range(0, 99) < 15);
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard and stall sequencer for the 5-stage RV32 core. It detects load-use hazards and taken-branch control hazards, and sequences multi-cycle EX operations (mul/div) through a start/done handshake. It drives stall and flush enables to the IF/ID, ID/EX and EX/MEM pipeline registers. It works alongside the operand forwarding network: forwarding covers ALU-to-ALU dependences, and this block covers everything forwarding cannot.

Parameters:
CNT_W, 32, width of the saturating performance counters
MD_TIMEOUT, 64, maximum cycles in BUSY before abort; must be ≥2

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
rs1D  in  5  rs1 of the instruction in ID
rs2D  in  5  rs2 of the instruction in ID
rdE  in  5  rd of the instruction in EX
MemReadE  in  1  EX instruction is a load
PCSrcE  in  1  taken branch/jump resolved in EX
MulDivE  in  1  EX instruction is a multi-cycle op
md_done  in  1  multi-cycle unit result valid (single-cycle pulse)
perf_clr  in  1  synchronous clear of both counters
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX (bubble)
FlushM  out  1  clear EX/MEM (bubble while EX is held)
md_start  out  1  one-cycle start pulse to the multi-cycle unit
md_busy  out  1  FSM not in IDLE
md_error  out  1  sticky timeout flag
stall_cycles  out  CNT_W  count of cycles with StallF=1
flush_events  out  CNT_W  count of branch flushes

Behaviour:
- FSM states: IDLE, BUSY. Reset → IDLE, timeout counter=0, md_error=0, both counters=0.
- While reset is high, all outputs are 0.
- lu = MemReadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- IDLE, MulDivE=1, PCSrcE=0:
  - md_start=1 for that cycle (Mealy).
  - StallF=StallD=StallE=1, FlushM=1.
  - Next state BUSY; timeout counter loaded with 0.
- BUSY, md_done=0:
  - StallF/D/E=1, FlushM=1, md_busy=1.
  - FlushD=FlushE=0, even if lu=1, so the held EX op is never killed.
  - Timeout counter increments.
- BUSY, md_done=1:
  - All stalls and FlushM deassert combinationally in the same cycle, so EX/MEM captures the result at that edge.
  - Next state IDLE.
  - If the next EX instruction also has MulDivE=1, a fresh start occurs in IDLE on the following cycle.
- BUSY timeout: if the timeout counter reaches MD_TIMEOUT-1 with md_done=0:
  - md_error ← 1 (sticky until reset); next state IDLE.
  - Stalls drop on the following cycle.
- md_done in IDLE is ignored.
- IDLE, MulDivE=0, with this priority:
  - PCSrcE=1: FlushD=FlushE=1, no stalls; lu is ignored because the younger instruction is squashed.
  - else lu=1: StallF=StallD=1, FlushE=1 (one bubble per hazard cycle).
  - else all stall/flush outputs are 0.
- rd=x0 never causes a load-use stall.
- stall_cycles: +1 each cycle StallF=1; saturates at all-ones.
- flush_events: +1 each cycle a branch flush asserts (PCSrcE path); saturates at all-ones.
- perf_clr=1 sets both counters to 0 at the edge and overrides increment that cycle.
- Asynchronous reset mid-BUSY returns to IDLE immediately; no md_start is emitted on exit.

Decomposition:
- Shared pipeline package holds:
  - FSM state enum (md_state_t: MD_IDLE, MD_BUSY)
  - REG_X0 constant (5'd0)
  - default CNT_W and MD_TIMEOUT constants.
- One sub-module, sat_counter (CNT_W, inc, clr), is instantiated twice for the performance counters.
- Hazard detection and the FSM stay in hazard_controller.

Test Plan:
- Load-use: MemReadE=1, rdE=5, rs1D=5 for one cycle → StallF=StallD=FlushE=1 for that cycle; stall_cycles=1 after the edge. Repeat with rdE=0 → no stall.
- Multi-cycle: MulDivE=1 at cycle 0, md_done=1 at cycle 4:
  - md_start=1 only at cycle 0.
  - StallF/D/E=1 and FlushM=1 during cycles 0–3, all 0 at cycle 4.
  - md_busy=1 during cycles 1–4.
  - Back in IDLE at cycle 5; stall_cycles=4.
- Branch and load-use together: PCSrcE=1 and lu=1 in the same cycle → FlushD=FlushE=1, StallF=0; flush_events=1.
- lu=1 during BUSY → FlushE stays 0 and stalls are held; no bubble is inserted.
- Timeout with MD_TIMEOUT=8: MulDivE=1, md_done never asserted → md_error=1 after 8 BUSY cycles, FSM returns to IDLE, and md_error stays 1 afterwards.
- Reset at BUSY cycle 2 → all outputs 0 immediately. After release, counters=0, md_error=0, and no md_start is seen until a new MulDivE.
